uart_loader_host: RTL and testbench
===================================

# uart_loader_host

Host-side initiator for the UART memory-load protocol served by the on-board I/O manager. Streams a 2^ADDR_W-byte image from a synchronous-read source memory out over a byte-level UART transmitter, then raises `dut_start` to request the image back and checks each returned byte against the source. Used as the board-to-board loader and as the far end of the loopback bench.

## Interface
- `ADDR_W`, 16, address width; image length is exactly 2^ADDR_W bytes.
- `TIMEOUT_W`, 24, readback watchdog width; a timeout fires after 2^TIMEOUT_W cycles with no `rx_done`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a session; ignored unless `busy`=0.
- `mem_addr`  out  ADDR_W  source memory address.
- `mem_rdata`  in  8  source data, valid one cycle after `mem_addr`.
- `tx_send`  out  1  one-cycle request to the UART transmitter.
- `tx_data`  out  8  byte to send; held stable from `tx_send` until `tx_ready` returns high.
- `tx_ready`  in  1  transmitter idle (high) / busy (low).
- `rx_done`  in  1  one-cycle pulse, received byte valid on `rx_data`.
- `rx_data`  in  8  received byte.
- `dut_start`  out  1  readback request to the far end.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse at session end.
- `error_count`  out  16  mismatched readback bytes, saturating.
- `timeout`  out  1  sticky; readback watchdog expired.
- `overrun`  out  1  sticky; `rx_data` arrived while a compare was in progress.

## Operation
- States: IDLE, LD_ADDR, LD_LATCH, LD_SEND, LD_ACK, LD_WAIT, KICK, RB_WAIT, RB_CMP, FINISH.
- IDLE: `start` -> clear `error_count`, `timeout`, and `overrun`; set address to 0; go to LD_ADDR.
- LD_ADDR -> LD_LATCH: `mem_addr` is valid, waiting one cycle for the read.
- LD_LATCH: `tx_data` <= `mem_rdata`; go to LD_SEND.
- LD_SEND: `tx_send`=1 for one cycle, only if `tx_ready`=1; otherwise stay in LD_SEND.
- LD_ACK: wait for `tx_ready`=0. This guards against a transmitter that reports busy late.
- LD_WAIT: wait for `tx_ready`=1, then {carry,addr} <= addr+1 using an ADDR_W+1-bit counter.
  - carry=0 -> LD_ADDR.
  - carry=1 -> KICK, with address wrapped to 0.
- KICK: `dut_start`=1. Go to RB_WAIT. `dut_start` stays high until the first `rx_done` of readback.
- RB_WAIT:
  - `rx_done` -> capture `rx_data`, drive `mem_addr` = readback address, go to RB_CMP.
  - The watchdog counts every RB_WAIT cycle and resets on each `rx_done`. On wrap: set `timeout`, go to FINISH.
- RB_CMP (2 cycles: read, then compare):
  - Mismatch -> `error_count`+1, saturating at 16'hFFFF.
  - Then increment the address. Carry -> FINISH, else RB_WAIT.
  - `rx_done` during RB_CMP -> set `overrun`; that byte is dropped and not counted.
- FINISH: `done`=1 for one cycle, go to IDLE.
- `busy`=1 in every state except IDLE.
- Reset mid-session: all state and outputs return to reset values immediately. The transmitter is not aborted; the host simply stops requesting.

## Timing
- Reset values: `mem_addr`=0, `tx_send`=0, `tx_data`=0, `dut_start`=0, `busy`=0, `done`=0, `error_count`=0, `timeout`=0, `overrun`=0. State is IDLE.
- `start` to first `tx_send`: 3 cycles (LD_ADDR, LD_LATCH, LD_SEND), when `tx_ready`=1.
- Per byte: 3 cycles plus the transmitter busy time.
- Last `tx_ready` rise to `dut_start`=1: 2 cycles.
- `rx_done` to `error_count` update: 2 cycles. Returned bytes must be spaced at least 3 cycles apart; closer bytes set `overrun`.
- All outputs are registered.

## Configuration
- `LOADER_VERIFY_EN` defined: full readback and compare, as above.
- Undefined:
  - KICK pulses `dut_start` for one cycle, then goes straight to FINISH.
  - RB_* states, the watchdog, and the comparator are not built.
  - `rx_*` inputs are ignored.
  - `error_count`, `timeout`, and `overrun` are tied to 0.

## Structure
- Shared package `loader_pkg`: state encoding (5-bit localparams), default ADDR_W/TIMEOUT_W, and the error-counter width and saturation constant.
- One sub-module, `loader_watchdog`: a TIMEOUT_W counter with clear/enable and an expire output.

## Test plan
- ADDR_W=4, memory[i]=i, loopback returns the same bytes -> 16 `tx_send` pulses carrying 0..15, then `dut_start`, then `done` with `error_count`=0.
- Same setup, but the far end returns byte 5 as 8'hFF -> `error_count`=1 at `done`; `timeout`=0.
- Far end returns only 10 of 16 bytes, TIMEOUT_W=8 -> `timeout`=1, then `done` 256 cycles after the 10th byte.
- `tx_ready` held low for 50 cycles before the first byte -> `tx_send` waits; first byte is 8'h00; no byte lost or duplicated.
- `reset_n` pulled low during byte 7 of load -> `busy`=0 and `tx_send`=0 immediately; a new `start` resends from address 0.
- Built without `LOADER_VERIFY_EN` -> after 16 bytes, `dut_start` pulses for 1 cycle and `done` follows 1 cycle later; `rx_done` pulses have no effect.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared definitions for the UART memory-load host: FSM state
//            encoding, default geometry and the readback error-counter
//            width / saturation value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_TIMEOUT_W = 24;

    localparam int                ERR_W   = 16;
    localparam logic [ERR_W-1:0]  ERR_MAX = 16'hFFFF;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] ST_IDLE     = 5'd0;
    localparam logic [STATE_W-1:0] ST_LD_ADDR  = 5'd1;
    localparam logic [STATE_W-1:0] ST_LD_LATCH = 5'd2;
    localparam logic [STATE_W-1:0] ST_LD_SEND  = 5'd3;
    localparam logic [STATE_W-1:0] ST_LD_ACK   = 5'd4;
    localparam logic [STATE_W-1:0] ST_LD_WAIT  = 5'd5;
    localparam logic [STATE_W-1:0] ST_KICK     = 5'd6;
    localparam logic [STATE_W-1:0] ST_RB_WAIT  = 5'd7;
    localparam logic [STATE_W-1:0] ST_RB_CMP   = 5'd8;
    localparam logic [STATE_W-1:0] ST_FINISH   = 5'd9;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = ST_IDLE,
        S_LD_ADDR  = ST_LD_ADDR,
        S_LD_LATCH = ST_LD_LATCH,
        S_LD_SEND  = ST_LD_SEND,
        S_LD_ACK   = ST_LD_ACK,
        S_LD_WAIT  = ST_LD_WAIT,
        S_KICK     = ST_KICK,
        S_RB_WAIT  = ST_RB_WAIT,
        S_RB_CMP   = ST_RB_CMP,
        S_FINISH   = ST_FINISH
    } state_t;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/loader_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : loader_watchdog
// Purpose  : Free-running TIMEOUT_W-bit idle counter for the readback phase.
//            Counts while enabled, returns to zero on clear, and flags
//            expiry on the cycle the counter would wrap.
// Ports    : clk, reset_n (async, active low), clear, enable -> expire
// Config   : only built when LOADER_VERIFY_EN is defined (readback path).
// Revision : 1.0 - initial release
// ============================================================================
`ifdef LOADER_VERIFY_EN
module loader_watchdog
    import loader_pkg::*;
#(
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TIMEOUT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
        end
    end

    // 2^TIMEOUT_W enabled cycles: the last one sees the all-ones count.
    assign expire = enable && (r_cnt == '1);

endmodule
`endif
`default_nettype wire

// File: rtl/uart_loader_host.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_host
// Purpose  : Host-side initiator of the UART memory-load protocol. Streams a
//            2^ADDR_W-byte image from a synchronous-read memory to a byte
//            UART transmitter, then requests the image back (dut_start) and
//            compares every returned byte against the source.
// Ports    : clk, reset_n (async, active low), start
//            mem_addr / mem_rdata      - source memory (1-cycle read latency)
//            tx_send / tx_data / tx_ready - UART transmitter handshake
//            rx_done / rx_data         - UART receiver byte strobe
//            dut_start, busy, done     - session control / status
//            error_count, timeout, overrun - readback results
// Config   : LOADER_VERIFY_EN defined  -> readback, watchdog and compare built.
//            LOADER_VERIFY_EN undefined -> load only; dut_start is a single
//            pulse, rx_* ignored, result outputs tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module uart_loader_host
    import loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              dut_start,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  error_count,
    output logic              timeout,
    output logic              overrun
);

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [ADDR_W:0]    w_addr_inc;
    logic               r_tx_send, w_tx_send_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_dut_start, w_dut_start_nxt;
    logic               r_busy;
    logic               r_done, w_done_nxt;

    // Extra bit catches the wrap past the last image byte.
    assign w_addr_inc = {1'b0, r_addr} + (ADDR_W+1)'(1);

`ifdef LOADER_VERIFY_EN
    logic [ERR_W-1:0]   r_err, w_err_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic               r_overrun, w_overrun_nxt;
    logic [7:0]         r_rx_byte, w_rx_byte_nxt;
    logic               r_cmp_phase, w_cmp_phase_nxt;
    logic               w_wd_en, w_wd_clear, w_wd_expire;

    // Watchdog only runs through idle RB_WAIT cycles; any other state or a
    // received byte restarts it.
    assign w_wd_en    = (r_state == S_RB_WAIT) && !rx_done;
    assign w_wd_clear = !w_wd_en;

    loader_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_wd_clear),
        .enable  (w_wd_en),
        .expire  (w_wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err       <= '0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
            r_rx_byte   <= '0;
            r_cmp_phase <= 1'b0;
        end else begin
            r_err       <= w_err_nxt;
            r_timeout   <= w_timeout_nxt;
            r_overrun   <= w_overrun_nxt;
            r_rx_byte   <= w_rx_byte_nxt;
            r_cmp_phase <= w_cmp_phase_nxt;
        end
    end

    assign error_count = r_err;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;
`else
    logic [8:0]  w_unused_rx;
    logic [31:0] w_unused_cfg;
    assign w_unused_rx  = {rx_done, rx_data};
    assign w_unused_cfg = TIMEOUT_W;

    assign error_count = '0;
    assign timeout     = 1'b0;
    assign overrun     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_tx_send   <= 1'b0;
            r_tx_data   <= '0;
            r_dut_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_tx_send   <= w_tx_send_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_dut_start <= w_dut_start_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_tx_send_nxt   = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_dut_start_nxt = r_dut_start;
        w_done_nxt      = 1'b0;
`ifdef LOADER_VERIFY_EN
        w_err_nxt       = r_err;
        w_timeout_nxt   = r_timeout;
        w_overrun_nxt   = r_overrun;
        w_rx_byte_nxt   = r_rx_byte;
        w_cmp_phase_nxt = r_cmp_phase;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_LD_ADDR;
`ifdef LOADER_VERIFY_EN
                    w_err_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                    w_overrun_nxt = 1'b0;
`endif
                end
            end
            S_LD_ADDR: begin
                w_state_nxt = S_LD_LATCH;
            end
            S_LD_LATCH: begin
                w_tx_data_nxt = mem_rdata;
                w_state_nxt   = S_LD_SEND;
            end
            S_LD_SEND: begin
                if (tx_ready) begin
                    w_tx_send_nxt = 1'b1;
                    w_state_nxt   = S_LD_ACK;
                end
            end
            S_LD_ACK: begin
                // Do not trust tx_ready until the transmitter has gone busy.
                if (!tx_ready) begin
                    w_state_nxt = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                if (tx_ready) begin
                    w_addr_nxt  = w_addr_inc[ADDR_W-1:0];
                    w_state_nxt = w_addr_inc[ADDR_W] ? S_KICK : S_LD_ADDR;
                end
            end
            S_KICK: begin
                w_dut_start_nxt = 1'b1;
`ifdef LOADER_VERIFY_EN
                w_state_nxt     = S_RB_WAIT;
`else
                w_state_nxt     = S_FINISH;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_RB_WAIT: begin
                if (rx_done) begin
                    w_rx_byte_nxt   = rx_data;
                    w_dut_start_nxt = 1'b0;
                    w_cmp_phase_nxt = 1'b0;
                    w_state_nxt     = S_RB_CMP;
                end else if (w_wd_expire) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_FINISH;
                end
            end
            S_RB_CMP: begin
                // A byte landing here cannot be queued; flag it and drop it.
                if (rx_done) begin
                    w_overrun_nxt = 1'b1;
                end
                if (!r_cmp_phase) begin
                    w_cmp_phase_nxt = 1'b1;
                end else begin
                    if (mem_rdata != r_rx_byte) begin
                        w_err_nxt = sat_inc(r_err);
                    end
                    w_addr_nxt  = w_addr_inc[ADDR_W-1:0];
                    w_state_nxt = w_addr_inc[ADDR_W] ? S_FINISH : S_RB_WAIT;
                end
            end
`endif
            S_FINISH: begin
                w_dut_start_nxt = 1'b0;
                w_done_nxt      = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_addr  = r_addr;
    assign tx_send   = r_tx_send;
    assign tx_data   = r_tx_data;
    assign dut_start = r_dut_start;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader_host
// Purpose  : Directed self-checking bench for uart_loader_host with a
//            16-byte image (memory[i] = i), a byte transmitter model and,
//            when LOADER_VERIFY_EN is defined, a scripted far end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_loader_host;

    localparam int ADDR_W    = 4;
    localparam int TIMEOUT_W = 8;
    localparam int N_BYTES   = 16;
    localparam int TX_BUSY   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              tx_send;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              dut_start;
    logic              busy;
    logic              done;
    logic [15:0]       error_count;
    logic              timeout;
    logic              overrun;

    always #5 clk = ~clk;

    uart_loader_host #(
        .ADDR_W    (ADDR_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .dut_start   (dut_start),
        .busy        (busy),
        .done        (done),
        .error_count (error_count),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    // Source memory, one-cycle synchronous read.
    logic [7:0] mem [N_BYTES];
    initial for (int i = 0; i < N_BYTES; i++) mem[i] = 8'(i);
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // Transmitter model: busy for TX_BUSY cycles after each send request.
    logic tx_ready_m = 1'b1;
    int   tx_cnt     = 0;
    logic tx_hold;
    assign tx_ready = tx_ready_m & ~tx_hold;
    always @(posedge clk) begin
        if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_ready_m <= 1'b1;
        end else if (tx_send) begin
            tx_ready_m <= 1'b0;
            tx_cnt     <= TX_BUSY;
        end
    end

    // Observation, on the falling edge.
    int         cyc = 0;
    logic [7:0] tx_log [$];
    int         last_rise = 0, ds_rise = 0, ds_len = 0;
    int         done_cnt = 0, done_cyc = 0, last_rx_cyc = 0;
    logic       busy_at_done = 1'b0;
    logic       prev_ready = 1'b1, prev_ds = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_send) tx_log.push_back(tx_data);
        if (tx_ready && !prev_ready) last_rise = cyc;
        prev_ready = tx_ready;
        if (dut_start && !prev_ds) ds_rise = cyc;
        if (dut_start) ds_len++;
        prev_ds = dut_start;
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic begin_session(output int snap);
        snap = done_cnt;
        tx_log.delete();
        ds_len = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int snap, input int max_cyc);
        int k = 0;
        while (done_cnt == snap && k < max_cyc) begin
            tick();
            k++;
        end
        check_value("done_seen", 32'(done_cnt != snap), 1);
    endtask

    task automatic check_log(input string tag);
        check_value({tag, "_count"}, tx_log.size(), N_BYTES);
        for (int i = 0; i < N_BYTES; i++)
            check_value(tag, (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD, i);
    endtask

`ifdef LOADER_VERIFY_EN
    task automatic wait_dut_start();
        int k = 0;
        while (!dut_start && k < 3000) begin
            tick();
            k++;
        end
        check_value("dut_start_seen", dut_start, 1);
    endtask

    // Far end: n bytes, byte bad_idx replaced by 8'hFF, gap cycles apart.
    task automatic reply(input int n, input int bad_idx, input int gap);
        for (int i = 0; i < n; i++) begin
            rx_data     = (i == bad_idx) ? 8'hFF : 8'(i);
            rx_done     = 1'b1;
            last_rx_cyc = cyc;
            tick();
            rx_done = 1'b0;
            repeat (gap - 1) tick();
        end
    endtask
`endif

    task automatic finish_session(input int snap);
`ifdef LOADER_VERIFY_EN
        wait_dut_start();
        reply(N_BYTES, -1, 4);
`endif
        wait_done(snap, 3000);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_time_limit: got cycle %0d, expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int snap;
        int k;
        int d;
        reset_n = 1'b0;
        start   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_hold = 1'b0;
        repeat (3) tick();

        // Reset values
        check_value("rst_mem_addr",  mem_addr, 0);
        check_value("rst_tx_send",   tx_send, 0);
        check_value("rst_tx_data",   tx_data, 0);
        check_value("rst_dut_start", dut_start, 0);
        check_value("rst_busy",      busy, 0);
        check_value("rst_done",      done, 0);
        check_value("rst_error",     error_count, 0);
        check_value("rst_timeout",   timeout, 0);
        check_value("rst_overrun",   overrun, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Session 1: clean load (and clean loopback when verifying)
        begin_session(snap);
        check_value("busy_after_start", busy, 1);
        k = 0;
        while (!tx_send && k < 20) begin
            tick();
            k++;
        end
        check_value("start_to_tx_send", k, 3);
        finish_session(snap);
        check_log("s1_byte");
        check_value("s1_kick_latency", ds_rise - last_rise, 2);
        check_value("s1_busy_at_done", busy_at_done, 0);
        check_value("s1_addr_wrap", mem_addr, 0);
        check_value("s1_error", error_count, 0);
        check_value("s1_timeout", timeout, 0);
        check_value("s1_overrun", overrun, 0);
`ifndef LOADER_VERIFY_EN
        check_value("s1_dut_start_width", ds_len, 1);
        check_value("s1_done_after_kick", done_cyc - ds_rise, 1);
`endif
        tick();

        // Session 2: transmitter busy for 50 cycles; stray rx strobes meanwhile
        tx_hold = 1'b1;
        begin_session(snap);
        for (int i = 0; i < 50; i++) begin
            rx_data = 8'hFF;
            rx_done = (i % 5 == 0);
            tick();
        end
        rx_done = 1'b0;
        check_value("s2_no_send_on_hold", tx_log.size(), 0);
        tx_hold = 1'b0;
        finish_session(snap);
        check_log("s2_byte");
        check_value("s2_error", error_count, 0);
        check_value("s2_timeout", timeout, 0);
        check_value("s2_overrun", overrun, 0);
`ifndef LOADER_VERIFY_EN
        check_value("s2_dut_start_width", ds_len, 1);
`endif
        tick();

        // Session 3: reset asserted while byte 7 is being requested
        begin_session(snap);
        k = 0;
        while (tx_log.size() < 7 && k < 500) begin
            tick();
            k++;
        end
        check_value("s3_reached_byte7", tx_log.size(), 7);
        check_value("s3_tx_send_pre_rst", tx_send, 1);
        reset_n = 1'b0;
        #1;
        check_value("s3_rst_busy", busy, 0);
        check_value("s3_rst_tx_send", tx_send, 0);
        check_value("s3_rst_mem_addr", mem_addr, 0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        begin_session(snap);
        finish_session(snap);
        check_log("s3_reload_byte");
        tick();

`ifdef LOADER_VERIFY_EN
        // Session 4: byte 5 corrupted by the far end
        begin_session(snap);
        wait_dut_start();
        reply(N_BYTES, 5, 4);
        wait_done(snap, 3000);
        check_value("s4_error", error_count, 1);
        check_value("s4_timeout", timeout, 0);
        check_value("s4_overrun", overrun, 0);
        tick();

        // Session 5: only 10 bytes return; watchdog ends the session
        begin_session(snap);
        wait_dut_start();
        reply(10, -1, 4);
        wait_done(snap, 3000);
        check_value("s5_timeout", timeout, 1);
        check_value("s5_error", error_count, 0);
        d = done_cyc - last_rx_cyc;
        check_value("s5_timeout_latency", 32'(d >= 256 && d <= 264), 1);
        tick();

        // Session 6: bytes 2 cycles apart; every odd byte is dropped
        begin_session(snap);
        wait_dut_start();
        reply(N_BYTES, -1, 2);
        wait_done(snap, 3000);
        check_value("s6_overrun", overrun, 1);
        check_value("s6_error", error_count, 7);
        check_value("s6_timeout", timeout, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
